// File: rtl/regfile_dump_restore.sv
// regfile_dump_restore
// Client-side sequencer for the register file. In dump mode it walks
// FIRST_REG..LAST_REG through the read port and streams each word out over
// a valid/ready interface. In restore mode it takes a valid/ready stream
// and writes the words into FIRST_REG..LAST_REG in order.
// The core is expected to stay stalled while busy is high.
module regfile_dump_restore #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIRST_REG  = 1,
  parameter int LAST_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_dump,
  input  logic                  start_restore,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  rf_write_en,
  output logic [ADDR_WIDTH-1:0] rf_write_dest,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DUMP,
    ST_RESTORE,
    ST_DONE
  } state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] idx_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic dump_active;
  logic restore_active;
  logic dump_xfer;
  logic restore_xfer;
  logic at_last;

  // Stream and write-port qualifiers. Abort and reset cut both ports off in
  // the same cycle so that neither a beat nor a register write can slip
  // through while the operation is being torn down.
  always_comb begin
    dump_active    = (state_reg == ST_DUMP) && !abort && !reset;
    restore_active = (state_reg == ST_RESTORE) && !abort && !reset;
    dump_xfer      = dump_active && out_ready;
    restore_xfer   = restore_active && in_valid;
    at_last        = (idx_reg == LAST_IDX);
  end

  // Datapath: the index drives both ports; data passes straight through so a
  // word can move every cycle. With out_ready low idx holds, so out_data and
  // out_index stay stable as long as the register file is left untouched.
  assign rf_read_addr  = idx_reg;
  assign out_data      = rf_read_data;
  assign out_index     = idx_reg;
  assign out_valid     = dump_active;
  assign in_ready      = restore_active;
  assign rf_write_en   = restore_xfer;
  assign rf_write_dest = idx_reg;
  assign rf_write_data = in_data;
  assign busy          = busy_reg;
  assign done          = done_reg;

  // Sequencer: mode selection, index walk, termination at LAST_REG (before
  // the increment, so idx never wraps), and the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= FIRST_IDX;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start_dump) begin
            state_reg <= ST_DUMP;
            busy_reg  <= 1'b1;
            idx_reg   <= FIRST_IDX;
          end else if (start_restore) begin
            state_reg <= ST_RESTORE;
            busy_reg  <= 1'b1;
            idx_reg   <= FIRST_IDX;
          end
        end
        ST_DUMP, ST_RESTORE: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            idx_reg   <= FIRST_IDX;
          end else if (dump_xfer || restore_xfer) begin
            if (at_last) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              idx_reg <= idx_reg + IDX_ONE;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          idx_reg   <= FIRST_IDX;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          idx_reg   <= FIRST_IDX;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_restore.sv
// Testbench for regfile_dump_restore: a behavioural register file sits on
// the DUT's ports, and an expected-contents array tracks what every register
// should hold from the transfer rules alone.
module tb_regfile_dump_restore;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int FIRST  = 1;
  localparam int LAST   = 31;
  localparam int NWORDS = LAST - FIRST + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start_dump, start_restore, abort;
  logic          busy, done, rf_write_en, out_valid, out_ready, in_valid, in_ready;
  logic [AW-1:0] rf_read_addr, rf_write_dest, out_index;
  logic [DW-1:0] rf_read_data, rf_write_data, out_data, in_data;

  // environment register file (r0 reads zero) and expected contents
  logic [DW-1:0] rf     [32];
  logic [DW-1:0] exp_rf [32];
  logic [DW-1:0] words  [NWORDS];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int write_cnt, done_cnt, busy_cycles, hs_cnt;
  logic [AW-1:0] beat_idx[$];
  logic [DW-1:0] beat_dat[$];
  logic          prev_stall;
  logic [AW-1:0] prev_idx;
  logic [DW-1:0] prev_dat;
  logic          s_busy, s_done, s_valid, s_wr, s_in_ready;
  logic [AW-1:0] s_idx, s_raddr;

  assign rf_read_data = (rf_read_addr == '0) ? '0 : rf[rf_read_addr];

  regfile_dump_restore #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIRST_REG(FIRST), .LAST_REG(LAST)
  ) dut (
    .clk(clk), .reset(reset), .start_dump(start_dump), .start_restore(start_restore),
    .abort(abort), .busy(busy), .done(done), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .rf_write_en(rf_write_en), .rf_write_dest(rf_write_dest),
    .rf_write_data(rf_write_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: inputs are already set (posedge+1); sample at posedge+2,
  // then let the edge land and apply any register-file write.
  task automatic cycle();
    logic          do_wr;
    logic [AW-1:0] wd;
    logic [DW-1:0] wdat;
    #1;
    do_wr      = 1'b0;
    wd         = '0;
    wdat       = '0;
    s_busy     = busy;
    s_done     = done;
    s_valid    = out_valid;
    s_idx      = out_index;
    s_wr       = rf_write_en;
    s_in_ready = in_ready;
    s_raddr    = rf_read_addr;
    if (busy) busy_cycles++;
    if (done) done_cnt++;
    if (out_valid) begin
      if (prev_stall) begin
        check_val("stall_hold_index", 32'(out_index), 32'(prev_idx));
        check_val("stall_hold_data", out_data, prev_dat);
      end
      if (out_ready) begin
        beat_idx.push_back(out_index);
        beat_dat.push_back(out_data);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_idx   = out_index;
    prev_dat   = out_data;
    if (rf_write_en) begin
      write_cnt++;
      check_val("write_needs_valid", 32'(in_valid), 32'd1);
      if (hs_cnt < NWORDS) begin
        check_val("write_dest", 32'(rf_write_dest), 32'(FIRST + hs_cnt));
        check_val("write_data", rf_write_data, words[hs_cnt]);
      end else begin
        check_val("write_overrun", 32'(hs_cnt), 32'(NWORDS - 1));
      end
      hs_cnt++;
      do_wr = 1'b1;
      wd    = rf_write_dest;
      wdat  = rf_write_data;
    end
    @(posedge clk);
    if (do_wr && wd != '0) rf[wd] = wdat;
    #1;
  endtask

  task automatic clear_counters();
    write_cnt   = 0;
    done_cnt    = 0;
    busy_cycles = 0;
    hs_cnt      = 0;
    prev_stall  = 1'b0;
    beat_idx.delete();
    beat_dat.delete();
  endtask

  // rdy_mode: 0 = ready held high, 1 = pattern 1,0,0,1, 2 = random
  task automatic run_dump(input int rdy_mode, input bit hold_restore, input string name);
    int n;
    int nb;
    clear_counters();
    start_dump    = 1'b1;
    start_restore = hold_restore;
    out_ready     = 1'b0;
    cycle();
    start_dump = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((n % 4) == 0) || ((n % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cycle();
      n++;
    end
    check_val({name, "_completed"}, 32'(done_cnt != 0), 32'd1);
    start_restore = 1'b0;
    out_ready     = 1'b0;
    cycle();
    check_val({name, "_busy_after_done"}, 32'(s_busy), 32'd0);
    check_val({name, "_done_single"}, 32'(done_cnt), 32'd1);
    nb = beat_idx.size();
    check_val({name, "_beats"}, 32'(nb), 32'(NWORDS));
    for (int k = 0; k < nb && k < NWORDS; k++) begin
      check_val({name, "_beat_index"}, 32'(beat_idx[k]), 32'(FIRST + k));
      check_val({name, "_beat_data"}, beat_dat[k], exp_rf[FIRST + k]);
    end
    check_val({name, "_no_writes"}, 32'(write_cnt), 32'd0);
    if (rdy_mode == 0) check_val({name, "_dump_cycles"}, 32'(busy_cycles), 32'(NWORDS));
    $display("%s: dump delivered %0d beats, %0d busy cycles, %0d done pulses",
             name, nb, busy_cycles, done_cnt);
  endtask

  // vld_mode: 0 = valid held high, 1 = every other cycle, 2 = random
  // abort_at >= 0: abort (with in_valid high) once that many words landed
  task automatic run_restore(input int vld_mode, input int abort_at, input string name);
    int n;
    int exp_writes;
    int bad;
    bit aborted;
    clear_counters();
    start_restore = 1'b1;
    in_valid      = 1'b0;
    cycle();
    start_restore = 1'b0;
    n       = 0;
    aborted = 1'b0;
    while (done_cnt == 0 && !aborted && n < 400) begin
      in_data = (hs_cnt < NWORDS) ? words[hs_cnt] : '0;
      if (abort_at >= 0 && hs_cnt == abort_at) begin
        abort    = 1'b1;
        in_valid = 1'b1;
        cycle();
        abort    = 1'b0;
        in_valid = 1'b0;
        aborted  = 1'b1;
        check_val({name, "_abort_no_write"}, 32'(s_wr), 32'd0);
        check_val({name, "_abort_no_ready"}, 32'(s_in_ready), 32'd0);
      end else begin
        case (vld_mode)
          0:       in_valid = 1'b1;
          1:       in_valid = ((n % 2) == 0);
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        cycle();
      end
      n++;
    end
    in_valid = 1'b0;
    check_val({name, "_completed"}, 32'(done_cnt != 0 || aborted), 32'd1);
    cycle();
    check_val({name, "_idle_busy"}, 32'(s_busy), 32'd0);
    check_val({name, "_idle_done"}, 32'(s_done), 32'd0);
    exp_writes = (abort_at >= 0) ? abort_at : NWORDS;
    check_val({name, "_writes"}, 32'(hs_cnt), 32'(exp_writes));
    check_val({name, "_done_pulses"}, 32'(done_cnt), (abort_at >= 0) ? 32'd0 : 32'd1);
    for (int k = 0; k < exp_writes; k++) exp_rf[FIRST + k] = words[k];
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      if (((r == 0) ? '0 : rf[r]) !== exp_rf[r]) bad++;
    end
    check_val({name, "_rf_mismatches"}, 32'(bad), 32'd0);
    $display("%s: restore wrote %0d words, %0d done pulses, %0d register mismatches",
             name, hs_cnt, done_cnt, bad);
  endtask

  initial begin
    int n;
    reset = 1'b1; start_dump = 1'b0; start_restore = 1'b0; abort = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int r = 0; r < 32; r++) begin
      rf[r]     = '0;
      exp_rf[r] = '0;
    end
    for (int k = 0; k < NWORDS; k++) words[k] = '0;
    clear_counters();
    @(posedge clk);
    #1;

    // reset state
    cycle();
    cycle();
    check_val("rst_busy", 32'(s_busy), 32'd0);
    check_val("rst_done", 32'(s_done), 32'd0);
    check_val("rst_out_valid", 32'(s_valid), 32'd0);
    check_val("rst_in_ready", 32'(s_in_ready), 32'd0);
    check_val("rst_write_en", 32'(s_wr), 32'd0);
    reset = 1'b0;
    cycle();
    check_val("idle_read_addr", 32'(s_raddr), 32'(FIRST));
    check_val("idle_busy", 32'(s_busy), 32'd0);
    $display("reset: busy=%0d done=%0d read_addr=%0d", s_busy, s_done, s_raddr);

    // preload r1..r31 = 0x100+i
    for (int r = 1; r < 32; r++) begin
      rf[r]     = 32'h100 + 32'(r);
      exp_rf[r] = 32'h100 + 32'(r);
    end

    run_dump(0, 1'b0, "t1_full_dump");
    run_dump(1, 1'b0, "t2_backpressure");

    for (int k = 0; k < NWORDS; k++) words[k] = 32'hA000 + 32'(k);
    run_restore(1, -1, "t3_gapped_restore");
    run_dump(0, 1'b0, "t3_readback");
    check_val("t3_r0_zero", rf_read_data & {DW{rf_read_addr == '0}}, '0);

    run_dump(1, 1'b1, "t4_both_starts");

    for (int k = 0; k < NWORDS; k++) words[k] = 32'hB000 + 32'(k);
    run_restore(0, 5, "t5_abort_restore");
    check_val("t5_r5_written", rf[5], 32'hB004);
    check_val("t5_r6_unchanged", rf[6], 32'hA005);
    run_dump(0, 1'b0, "t5_redump");

    // reset in the middle of a dump, at index 10
    clear_counters();
    start_dump = 1'b1;
    cycle();
    start_dump = 1'b0;
    out_ready  = 1'b1;
    n = 0;
    s_valid = 1'b0;
    while (!(s_valid && s_idx == AW'(9)) && n < 100) begin
      cycle();
      n++;
    end
    check_val("t6_reached_index9", 32'(s_idx), 32'd9);
    reset = 1'b1;
    cycle();
    check_val("t6_reset_cycle_index", 32'(s_idx), 32'd10);
    check_val("t6_reset_cycle_no_write", 32'(s_wr), 32'd0);
    reset = 1'b0;
    out_ready = 1'b0;
    cycle();
    check_val("t6_after_valid", 32'(s_valid), 32'd0);
    check_val("t6_after_busy", 32'(s_busy), 32'd0);
    check_val("t6_after_done", 32'(s_done), 32'd0);
    check_val("t6_no_done", 32'(done_cnt), 32'd0);
    $display("t6_reset_mid_dump: stopped after %0d beats", beat_idx.size());
    run_dump(0, 1'b0, "t6_restart");

    // randomized restore/dump rounds
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < NWORDS; k++) words[k] = $urandom;
      run_restore(2, -1, "rand_restore");
      run_dump(2, 1'b0, "rand_dump");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
